// File: rtl/axi4_lite_pkg.sv
// Shared constants for the dual-port core-to-AXI4-Lite bridge:
// response codes, protection encodings, FSM state encoding and port ids.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_INSTR = 3'b100;
    localparam logic [2:0] PROT_DATA  = 3'b000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

    localparam logic PORT_INSTR = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi4_lite_dual_master_if.sv
// AXI4-Lite bus between the bridge (master) and a slave.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both
// high; the source holds valid and payload stable until then, ready is independent of valid.
interface axi4_lite_dual_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  AWvalid;
    logic                  AWready;
    logic [ADDR_WIDTH-1:0] AWaddr;
    logic [2:0]            AWprot;

    logic                  Wvalid;
    logic                  Wready;
    logic [DATA_WIDTH-1:0] Wdata;
    logic [STRB_WIDTH-1:0] Wstrb;

    logic                  Bvalid;
    logic                  Bready;
    logic [1:0]            Bresp;

    logic                  ARvalid;
    logic                  ARready;
    logic [ADDR_WIDTH-1:0] ARaddr;
    logic [2:0]            ARprot;

    logic                  Rvalid;
    logic                  Rready;
    logic [DATA_WIDTH-1:0] Rdata;
    logic [1:0]            Rresp;

    modport master (
        output AWvalid, AWaddr, AWprot, input AWready,
        output Wvalid, Wdata, Wstrb, input Wready,
        input Bvalid, Bresp, output Bready,
        output ARvalid, ARaddr, ARprot, input ARready,
        input Rvalid, Rdata, Rresp, output Rready
    );

    modport slave (
        input AWvalid, AWaddr, AWprot, output AWready,
        input Wvalid, Wdata, Wstrb, output Wready,
        output Bvalid, Bresp, input Bready,
        input ARvalid, ARaddr, ARprot, output ARready,
        output Rvalid, Rdata, Rresp, input Rready
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant while enabled,
// pointer remembers the last granted input and flips priority on each grant.
module rr_arbiter2
    import axi4_lite_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Bit index of req/gnt equals the port id.
    logic last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && req[1]) begin
                gnt = (last == PORT_DATA) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last <= PORT_DATA;
        end else if (|gnt) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/axi4_lite_dual_master.sv
// Bridges the core's instruction-fetch and data req/gnt/rvalid ports onto one
// AXI4-Lite master, one transaction at a time, arbitrated round-robin.
module axi4_lite_dual_master
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic                    instr_err_o,

    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_err_o,

    axi4_lite_dual_master_if.master axi,

    output logic [2:0]              dbg_state
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [2:0]            state;
    logic                  port;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic                  aw_done;
    logic                  w_done;
    logic [1:0]            gnt;

    // Grants are only offered in IDLE and never while reset is held.
    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (reset && (state == ST_IDLE)),
        .req   ({data_req_i, instr_req_i}),
        .gnt   (gnt)
    );

    assign instr_gnt_o = gnt[PORT_INSTR];
    assign data_gnt_o  = gnt[PORT_DATA];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            port          <= PORT_INSTR;
            addr_q        <= '0;
            wdata_q       <= '0;
            strb_q        <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            instr_rdata_o <= '0;
            instr_err_o   <= 1'b0;
            data_rdata_o  <= '0;
            data_err_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        port    <= gnt[PORT_DATA];
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (gnt[PORT_DATA]) begin
                            addr_q  <= data_addr_i;
                            wdata_q <= data_wdata_i;
                            strb_q  <= data_be_i;
                            state   <= data_we_i ? ST_WR_REQ : ST_RD_ADDR;
                        end else begin
                            addr_q  <= instr_addr_i;
                            wdata_q <= '0;
                            strb_q  <= '0;
                            state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (axi.ARready) begin
                        state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (axi.Rvalid) begin
                        if (port == PORT_DATA) begin
                            data_rdata_o <= axi.Rdata;
                            data_err_o   <= resp_is_err(axi.Rresp);
                        end else begin
                            instr_rdata_o <= axi.Rdata;
                            instr_err_o   <= resp_is_err(axi.Rresp);
                        end
                        state <= ST_RESP;
                    end
                end
                ST_WR_REQ: begin
                    // AW and W complete independently; leave once both have.
                    if (axi.AWready) aw_done <= 1'b1;
                    if (axi.Wready)  w_done  <= 1'b1;
                    if ((aw_done || axi.AWready) && (w_done || axi.Wready)) begin
                        state <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (axi.Bvalid) begin
                        data_rdata_o <= '0;
                        data_err_o   <= resp_is_err(axi.Bresp);
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign axi.ARvalid = (state == ST_RD_ADDR);
    assign axi.ARaddr  = addr_q;
    assign axi.ARprot  = (port == PORT_INSTR) ? PROT_INSTR : PROT_DATA;
    assign axi.Rready  = (state == ST_RD_DATA);

    assign axi.AWvalid = (state == ST_WR_REQ) && !aw_done;
    assign axi.AWaddr  = addr_q;
    assign axi.AWprot  = PROT_DATA;
    assign axi.Wvalid  = (state == ST_WR_REQ) && !w_done;
    assign axi.Wdata   = wdata_q;
    assign axi.Wstrb   = strb_q;
    assign axi.Bready  = (state == ST_WR_RESP);

    assign instr_rvalid_o = (state == ST_RESP) && (port == PORT_INSTR);
    assign data_rvalid_o  = (state == ST_RESP) && (port == PORT_DATA);

    assign dbg_state = state;

endmodule

// File: tb/tb_axi4_lite_dual_master.sv
// Directed bench for axi4_lite_dual_master: a table of single transactions
// against a delay-programmable AXI slave, plus reset and arbitration sequences.
module tb_axi4_lite_dual_master;
    import axi4_lite_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_rdata;
    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_gnt, data_rvalid, data_err;
    logic [31:0] data_rdata;
    logic [2:0]  dbg_state;

    axi4_lite_dual_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi4_lite_dual_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .axi            (axi),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = RESP_OKAY;
    logic [1:0]  s_bresp = RESP_OKAY;

    int   ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic r_pend = 1'b0, b_pend = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;

    wire aw_hs = axi.AWvalid && axi.AWready;
    wire w_hs  = axi.Wvalid && axi.Wready;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
        end else begin
            if (axi.ARvalid && axi.ARready) begin
                ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= 0;
            end else if (axi.ARvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (axi.Rvalid && axi.Rready) r_pend <= 1'b0;
            else if (r_pend) r_cnt <= r_cnt + 1;
            if (aw_hs) aw_cnt <= 0; else if (axi.AWvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) w_cnt <= 0; else if (axi.Wvalid) w_cnt <= w_cnt + 1;
            if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
                b_pend <= 1'b1; b_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
            end else begin
                if (aw_hs) aw_seen <= 1'b1;
                if (w_hs)  w_seen  <= 1'b1;
            end
            if (axi.Bvalid && axi.Bready) b_pend <= 1'b0;
            else if (b_pend) b_cnt <= b_cnt + 1;
        end
    end

    initial begin
        axi.ARready = 1'b0; axi.AWready = 1'b0; axi.Wready = 1'b0;
        axi.Rvalid = 1'b0; axi.Rdata = '0; axi.Rresp = '0;
        axi.Bvalid = 1'b0; axi.Bresp = '0;
        forever begin
            @(negedge clk);
            axi.ARready = axi.ARvalid && (ar_cnt >= ar_delay);
            axi.AWready = axi.AWvalid && (aw_cnt >= aw_delay);
            axi.Wready  = axi.Wvalid && (w_cnt >= w_delay);
            axi.Rvalid  = r_pend && (r_cnt >= r_delay);
            axi.Rdata   = s_rdata;
            axi.Rresp   = s_rresp;
            axi.Bvalid  = b_pend && (b_cnt >= b_delay);
            axi.Bresp   = s_bresp;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_data;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ar_d, r_d, aw_d, w_d, b_d;
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        logic [2:0]  exp_prot;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] last_instr_rdata = '0;
    logic [31:0] last_data_rdata  = '0;

    task automatic run_vec(input vec_t v, input string tag);
        int   t0, ar_n, aw_n, w_n;
        bit   got, seen_ar, seen_aw, seen_w;
        logic rv, other_rv;
        ar_delay = v.ar_d; r_delay = v.r_d; aw_delay = v.aw_d; w_delay = v.w_d; b_delay = v.b_d;
        s_rdata = v.s_rdata; s_rresp = v.s_resp; s_bresp = v.s_resp;
        @(negedge clk);
        if (v.is_data) begin
            data_req = 1'b1; data_we = v.we; data_be = v.be; data_addr = v.addr; data_wdata = v.wdata;
        end else begin
            instr_req = 1'b1; instr_addr = v.addr;
        end
        #1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (v.is_data ? data_gnt : instr_gnt) begin got = 1; break; end
            @(negedge clk); #1;
        end
        check({tag, "_gnt"}, got, 1);
        check({tag, "_gnt_other"}, v.is_data ? instr_gnt : data_gnt, 0);
        t0 = cyc;
        @(negedge clk);
        instr_req = 1'b0; data_req = 1'b0;
        #1;
        got = 0; ar_n = 0; aw_n = 0; w_n = 0; seen_ar = 0; seen_aw = 0; seen_w = 0;
        for (int i = 0; i < 40; i++) begin
            if (axi.ARvalid) begin
                ar_n++;
                if (!seen_ar) begin
                    seen_ar = 1;
                    check({tag, "_araddr"}, axi.ARaddr, v.addr);
                    check({tag, "_arprot"}, axi.ARprot, v.exp_prot);
                end
            end
            if (axi.AWvalid) begin
                aw_n++;
                if (!seen_aw) begin
                    seen_aw = 1;
                    check({tag, "_awaddr"}, axi.AWaddr, v.addr);
                    check({tag, "_awprot"}, axi.AWprot, 3'b000);
                end
            end
            if (axi.Wvalid) begin
                w_n++;
                if (!seen_w) begin
                    seen_w = 1;
                    check({tag, "_wdata"}, axi.Wdata, v.wdata);
                    check({tag, "_wstrb"}, axi.Wstrb, v.be);
                end
            end
            rv       = v.is_data ? data_rvalid : instr_rvalid;
            other_rv = v.is_data ? instr_rvalid : data_rvalid;
            if (other_rv) check({tag, "_other_rvalid"}, other_rv, 0);
            if (rv) begin got = 1; break; end
            @(negedge clk); #1;
        end
        check({tag, "_rvalid"}, got, 1);
        check({tag, "_latency"}, cyc - t0, v.exp_lat);
        check({tag, "_rdata"}, v.is_data ? data_rdata : instr_rdata, v.exp_rdata);
        check({tag, "_err"}, v.is_data ? data_err : instr_err, v.exp_err);
        check({tag, "_other_rdata_held"}, v.is_data ? instr_rdata : data_rdata,
              v.is_data ? last_instr_rdata : last_data_rdata);
        if (v.is_data && v.we) begin
            check({tag, "_aw_cycles"}, aw_n, v.aw_d + 1);
            check({tag, "_w_cycles"}, w_n, v.w_d + 1);
            check({tag, "_no_ar"}, ar_n, 0);
        end else begin
            check({tag, "_ar_cycles"}, ar_n, v.ar_d + 1);
            check({tag, "_no_aw_w"}, aw_n + w_n, 0);
        end
        @(negedge clk); #1;
        check({tag, "_pulse_end"}, v.is_data ? data_rvalid : instr_rvalid, 0);
        check({tag, "_rdata_hold"}, v.is_data ? data_rdata : instr_rdata, v.exp_rdata);
        if (v.is_data) last_data_rdata = v.exp_rdata;
        else           last_instr_rdata = v.exp_rdata;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   n, prev;
        bit   got;
        vec_t rec;

        vecs[0] = '{1'b0, 1'b0, 4'h0,    32'h0000_1000, 32'h0,          0, 0, 0, 0, 0,
                    32'hFFFF_CCCC, RESP_OKAY,   3'b100, 32'hFFFF_CCCC, 1'b0, 3};
        vecs[1] = '{1'b1, 1'b1, 4'b0011, 32'h0000_2004, 32'hAAAA_CCCC, 0, 0, 2, 0, 0,
                    32'h0,         RESP_OKAY,   3'b000, 32'h0,         1'b0, 5};
        vecs[2] = '{1'b1, 1'b0, 4'hF,    32'h0000_3008, 32'h0,          1, 2, 0, 0, 0,
                    32'h1234_5678, RESP_EXOKAY, 3'b000, 32'h1234_5678, 1'b0, 6};
        vecs[3] = '{1'b0, 1'b0, 4'h0,    32'h0000_1004, 32'h0,          0, 0, 0, 0, 0,
                    32'hDEAD_BEEF, RESP_DECERR, 3'b100, 32'hDEAD_BEEF, 1'b1, 3};
        vecs[4] = '{1'b1, 1'b1, 4'hF,    32'h0000_2008, 32'h5555_AAAA, 0, 0, 0, 0, 0,
                    32'hCAFE_F00D, RESP_SLVERR, 3'b000, 32'h0,         1'b1, 3};
        vecs[5] = '{1'b1, 1'b1, 4'h0,    32'h0000_200C, 32'h0BAD_0BAD, 0, 0, 0, 3, 1,
                    32'h0,         RESP_OKAY,   3'b000, 32'h0,         1'b0, 7};
        vecs[6] = '{1'b1, 1'b0, 4'h0,    32'h0000_0003, 32'h0,          0, 0, 0, 0, 0,
                    32'h8765_4321, RESP_SLVERR, 3'b000, 32'h8765_4321, 1'b1, 3};
        vecs[7] = '{1'b0, 1'b0, 4'h0,    32'hFFFF_FFFC, 32'h0,          2, 0, 0, 0, 0,
                    32'h0F0F_0F0F, RESP_OKAY,   3'b100, 32'h0F0F_0F0F, 1'b0, 5};
        rec     = '{1'b1, 1'b0, 4'hF,    32'h0000_5000, 32'h0,          0, 0, 0, 0, 0,
                    32'h7777_1111, RESP_OKAY,   3'b000, 32'h7777_1111, 1'b0, 3};

        // Reset held with both ports requesting.
        reset = 1'b0;
        instr_req = 1'b1; instr_addr = 32'h0000_1000;
        data_req = 1'b1; data_we = 1'b0; data_be = '0; data_addr = 32'h0000_2000; data_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_instr_gnt", instr_gnt, 0);
        check("rst_data_gnt", data_gnt, 0);
        check("rst_axi_valids", {axi.ARvalid, axi.AWvalid, axi.Wvalid}, 3'b000);
        check("rst_axi_readies", {axi.Rready, axi.Bready}, 2'b00);
        check("rst_rvalids", {instr_rvalid, data_rvalid}, 2'b00);
        check("rst_errs", {instr_err, data_err}, 2'b00);
        check("rst_rdata", {instr_rdata, data_rdata}, 64'h0);
        check("rst_state", dbg_state, ST_IDLE);
        reset = 1'b1;
        #1;
        check("rel_instr_first", instr_gnt, 1);
        check("rel_data_waits", data_gnt, 0);
        instr_req = 1'b0; data_req = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while the slave withholds Rvalid in RD_DATA.
        ar_delay = 0; r_delay = 1000;
        @(negedge clk);
        instr_req = 1'b1; instr_addr = 32'h0000_4000;
        #1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (instr_gnt) begin got = 1; break; end
            @(negedge clk); #1;
        end
        check("mid_gnt", got, 1);
        @(negedge clk);
        instr_req = 1'b0;
        #1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (axi.Rready) begin got = 1; break; end
            @(negedge clk); #1;
        end
        check("mid_in_rd_data", got, 1);
        check("mid_state_rd_data", dbg_state, ST_RD_DATA);
        reset = 1'b0;
        @(negedge clk); #1;
        check("mid_arvalid_drop", axi.ARvalid, 0);
        check("mid_rready_drop", axi.Rready, 0);
        check("mid_state_idle", dbg_state, ST_IDLE);
        check("mid_rdata_cleared", instr_rdata, 32'h0);
        reset = 1'b1; r_delay = 0;
        n = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (instr_rvalid || data_rvalid) n++;
        end
        check("mid_no_rvalid", n, 0);
        last_instr_rdata = '0; last_data_rdata = '0;
        run_vec(rec, "recover");

        // Both ports requesting continuously with a zero-wait slave.
        ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
        s_rdata = 32'h3C3C_A5A5; s_rresp = RESP_OKAY;
        @(negedge clk);
        instr_req = 1'b1; instr_addr = 32'h0000_6000;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_7000;
        #1;
        n = 0; prev = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            if (instr_gnt || data_gnt) begin
                check("alt_one_hot", instr_gnt && data_gnt, 0);
                check($sformatf("alt_port%0d", n), data_gnt, n % 2);
                if (n > 0) check($sformatf("alt_spacing%0d", n), cyc - prev, 4);
                prev = cyc;
                n++;
            end
            @(negedge clk); #1;
        end
        check("alt_count", n, 6);
        instr_req = 1'b0; data_req = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("alt_instr_rdata", instr_rdata, 32'h3C3C_A5A5);
        check("alt_data_rdata", data_rdata, 32'h3C3C_A5A5);
        check("alt_final_idle", dbg_state, ST_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi4_lite_dual_master.md
Name: axi4_lite_dual_master

Overview:
- Next-generation core-to-AXI4-Lite master bridge.
- Accepts the core's instruction-fetch port (read-only) and data port (read/write) using the req/gnt/rvalid protocol.
- Arbitrates between the two ports round-robin and issues one AXI4-Lite transaction at a time.
- Returns read data and error status to the granted port.
- Generalises the single-channel bridge:
  - parametrised address and data widths;
  - byte-enable writes;
  - PROT encoding;
  - response-error reporting.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
- ADDR_WIDTH, 32, address width in bits.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width; derived, do not override.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- instr_req_i  input  1  instruction fetch request.
- instr_addr_i  input  ADDR_WIDTH  fetch address.
- instr_gnt_o  output  1  fetch request accepted (combinational).
- instr_rvalid_o  output  1  fetch data valid; one-cycle pulse.
- instr_rdata_o  output  DATA_WIDTH  fetch data.
- instr_err_o  output  1  fetch error; valid with instr_rvalid_o.
- data_req_i  input  1  data request.
- data_we_i  input  1  1 = write, 0 = read.
- data_be_i  input  STRB_WIDTH  byte enables for writes.
- data_addr_i  input  ADDR_WIDTH  data address.
- data_wdata_i  input  DATA_WIDTH  write data.
- data_gnt_o  output  1  data request accepted (combinational).
- data_rvalid_o  output  1  data response valid; one-cycle pulse.
- data_rdata_o  output  DATA_WIDTH  read data; 0 for writes.
- data_err_o  output  1  data error; valid with data_rvalid_o.
- AWvalid / AWready / AWaddr / AWprot  out / in / out / out  1 / 1 / ADDR_WIDTH / 3  AXI write-address channel.
- Wvalid / Wready / Wdata / Wstrb  out / in / out / out  1 / 1 / DATA_WIDTH / STRB_WIDTH  AXI write-data channel.
- Bvalid / Bready / Bresp  in / out / in  1 / 1 / 2  AXI write-response channel.
- ARvalid / ARready / ARaddr / ARprot  out / in / out / out  1 / 1 / ADDR_WIDTH / 3  AXI read-address channel.
- Rvalid / Rready / Rdata / Rresp  in / out / in / in  1 / 1 / DATA_WIDTH / 2  AXI read-data channel.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state = IDLE; all AXI valid/ready outputs = 0;
  - all gnt/rvalid/err outputs = 0; rdata outputs = 0;
  - address/data/strobe registers = 0; round-robin pointer favours instr.
- Reset mid-transaction:
  - abandons the transaction immediately;
  - no rvalid pulse is produced;
  - valids drop at that edge.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE:
  - gnt is asserted combinationally to exactly one requesting port.
  - Single request: that port wins.
  - Both requesting: the port not granted last wins (round-robin pointer updated on each grant).
  - On grant, latch addr, we, be, wdata and the port id.
  - Instr grant, or data grant with we=0 -> RD_ADDR. Data grant with we=1 -> WR_REQ.
  - gnt is never asserted outside IDLE.
- RD_ADDR:
  - ARvalid=1, ARaddr = latched addr.
  - ARprot = 3'b100 for instr, 3'b000 for data.
  - ARvalid holds until ARready; on ARready -> RD_DATA.
- RD_DATA:
  - Rready=1.
  - On Rvalid: capture Rdata into the granted port's rdata register; err = Rresp[1] (SLVERR/DECERR) -> RESP.
- WR_REQ:
  - AWvalid and Wvalid asserted together on entry.
  - Each drops independently the cycle after its own handshake (AWready / Wready); the completed-handshake flags are tracked.
  - Both done (same cycle or different cycles) -> WR_RESP.
  - Wstrb = latched be; AWprot = 3'b000.
- WR_RESP:
  - Bready=1.
  - On Bvalid: err = Bresp[1]; rdata = 0 -> RESP.
- RESP:
  - Granted port's rvalid_o = 1 for exactly one cycle, with rdata/err stable -> IDLE.
  - rdata/err hold their value until the next response.
- Latency:
  - With zero-wait slave, gnt cycle N gives rvalid at N+3 for reads and N+3 for writes.
  - Back-to-back: next gnt is possible at N+4.
- Address is passed unmodified, with no alignment check.
- Requests with be=0 are still issued, with Wstrb=0.
- No simultaneous AXI read and write; at most one outstanding transaction.
- Ready inputs are ignored outside their states; spurious Rvalid/Bvalid are not consumed.

Decomposition:
- Shared package axi4_lite_pkg:
  - resp codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - PROT_INSTR=3'b100, PROT_DATA=3'b000;
  - state encoding constants;
  - port-id constants PORT_INSTR=0, PORT_DATA=1.
- One sub-module: rr_arbiter2 (2-input round-robin, combinational grant, registered pointer updated on accept).

Test Plan:
- Reset held low with both requests high -> no gnt, all AXI valids 0. Release -> instr granted first.
- Instr read of 0x0000_1000, ARready=1, Rvalid=1, Rdata=0xFFFF_CCCC, Rresp=OKAY -> ARprot=3'b100; instr_rvalid_o pulses 3 cycles after gnt with rdata 0xFFFF_CCCC, err=0.
- Data write to 0x0000_2004, wdata 0xAAAA_CCCC, be=4'b0011; AWready delayed 2 cycles, Wready immediate -> Wvalid drops after 1 cycle, AWvalid holds 3 cycles, Wstrb=0011, single data_rvalid_o with err=0.
- instr_req_i and data_req_i held high continuously with zero-wait slave -> grants alternate instr, data, instr, data; each gnt is 4 cycles apart.
- Read with Rresp=DECERR, then write with Bresp=SLVERR -> err=1 on each respective rvalid pulse; rdata=0 for the write.
- reset asserted while in RD_DATA with Rvalid withheld -> ARvalid/Rready drop, no rvalid pulse; the next request completes normally.
